serial_to_parallel_rx: RTL and testbench

Stereo serial-to-parallel receiver for the MSDAP input path. It takes the framed, MSB-first serial bit streams produced by `parallel_to_serial` for the left and right channels and assembles them into 16-bit words. Completed L/R word pairs go into a small FIFO, which hands them to the MSDAP controller over a valid/ready handshake. It also reports FIFO overflow, framing errors and a received-word count.

---
 rtl/serial_to_parallel_rx.sv | 212 +++++++++++++++++++++
 tb/tb_serial_to_parallel_rx.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_to_parallel_rx.sv
// -----------------------------------------------------------------------------
// serial_to_parallel_rx
//
// Stereo serial-to-parallel receiver for the MSDAP input path. Two MSB-first
// serial streams (left/right) framed by a one-cycle `frame` strobe on the MSB
// are assembled into WIDTH-bit words. Each completed L/R pair is pushed into a
// small circular FIFO that is drained over a valid/ready handshake.
//
// Optional feature macro: S2P_FRAME_CHECK_EN
//   defined   - a frame seen while a word is in progress flags frame_err,
//               discards the partial word and restarts capture on that edge.
//   undefined - frames during a word are ignored; frame_err is tied to 0.
//
// Parameters:
//   WIDTH      bits per serial word
//   FIFO_DEPTH word-pair buffer entries (power of two, >= 2)
//   CNT_WIDTH  width of word_cnt
//
// Ports:
//   clk        in   data clock, all logic on posedge
//   reset      in   asynchronous, active-low reset
//   frame      in   word-start strobe, coincident with the MSB
//   serial_L   in   left-channel serial data, MSB first
//   serial_R   in   right-channel serial data, MSB first
//   out_ready  in   consumer accepts the head pair
//   out_valid  out  FIFO non-empty
//   data_L     out  head left word (holds last head when empty)
//   data_R     out  head right word (holds last head when empty)
//   overflow   out  sticky, a completed pair was dropped
//   frame_err  out  sticky, mid-word frame seen
//   word_cnt   out  pairs completed (wraps)
// -----------------------------------------------------------------------------
module serial_to_parallel_rx #(
  parameter int WIDTH      = 16,
  parameter int FIFO_DEPTH = 2,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 frame,
  input  logic                 serial_L,
  input  logic                 serial_R,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     data_L,
  output logic [WIDTH-1:0]     data_R,
  output logic                 overflow,
  output logic                 frame_err,
  output logic [CNT_WIDTH-1:0] word_cnt
);

  localparam int BIT_W  = $clog2(WIDTH);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t state, next_state;

  logic [BIT_W-1:0] bit_cnt;
  // Only WIDTH-1 bits are stored: the LSB is taken straight from the serial
  // input on the completion edge.
  logic [WIDTH-2:0] shift_l, shift_r;
  logic [WIDTH-1:0] asm_l, asm_r;
  logic             load_msb, shift_en, push;
`ifdef S2P_FRAME_CHECK_EN
  logic             mid_frame;
`endif

  logic [WIDTH-1:0]  mem_l [FIFO_DEPTH];
  logic [WIDTH-1:0]  mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr, head_idx;
  logic [FCNT_W-1:0] fifo_cnt, remain;
  logic              pop, full, push_ok, drop;

  assign asm_l = {shift_l, serial_L};
  assign asm_r = {shift_r, serial_R};

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state and control decode. The completion edge is the SHIFT edge with
  // bit_cnt at zero; that edge samples bit 0 and pushes the pair.
  always_comb begin
    next_state = state;
    load_msb   = 1'b0;
    shift_en   = 1'b0;
    push       = 1'b0;
`ifdef S2P_FRAME_CHECK_EN
    mid_frame  = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (frame) begin
          load_msb   = 1'b1;
          next_state = SHIFT;
        end
      end
      SHIFT: begin
`ifdef S2P_FRAME_CHECK_EN
        if (frame) begin
          mid_frame = 1'b1;
          load_msb  = 1'b1;
        end else begin
          shift_en = 1'b1;
          if (bit_cnt == '0) begin
            push       = 1'b1;
            next_state = IDLE;
          end
        end
`else
        shift_en = 1'b1;
        if (bit_cnt == '0) begin
          push       = 1'b1;
          next_state = IDLE;
        end
`endif
      end
      default: next_state = IDLE;
    endcase
  end

  // Shift registers and bit counter. A load shifts just like a normal bit;
  // stale bits fall off the top before the word completes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift_l <= '0;
      shift_r <= '0;
      bit_cnt <= '0;
    end else begin
      if (load_msb || shift_en) begin
        shift_l <= asm_l[WIDTH-2:0];
        shift_r <= asm_r[WIDTH-2:0];
      end
      if (load_msb)      bit_cnt <= BIT_W'(WIDTH - 2);
      else if (shift_en) bit_cnt <= bit_cnt - BIT_W'(1);
    end
  end

  // A pop on the same edge frees a slot, so a push into a full FIFO is still
  // accepted when the consumer is draining.
  assign out_valid = (fifo_cnt != '0);
  assign pop       = out_valid && out_ready;
  assign full      = (fifo_cnt == FCNT_W'(FIFO_DEPTH));
  assign push_ok   = push && (!full || pop);
  assign drop      = push && full && !pop;
  assign remain    = fifo_cnt - FCNT_W'(pop);
  assign head_idx  = rd_ptr + PTR_W'(pop);

  // FIFO storage and pointers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_l[i] <= '0;
        mem_r[i] <= '0;
      end
    end else begin
      if (push_ok) begin
        mem_l[wr_ptr] <= asm_l;
        mem_r[wr_ptr] <= asm_r;
        wr_ptr        <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      fifo_cnt <= fifo_cnt + FCNT_W'(push_ok) - FCNT_W'(pop);
    end
  end

  // Registered head outputs. If entries survive this edge the next head is
  // already in memory; otherwise a pair arriving into an emptying FIFO becomes
  // the head directly; with nothing left the last head is held.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_L <= '0;
      data_R <= '0;
    end else if (remain != '0) begin
      data_L <= mem_l[head_idx];
      data_R <= mem_r[head_idx];
    end else if (push_ok) begin
      data_L <= asm_l;
      data_R <= asm_r;
    end
  end

  // Status: sticky overflow and the completed-pair counter, which counts
  // dropped pairs too.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
      word_cnt <= '0;
    end else begin
      if (drop) overflow <= 1'b1;
      if (push) word_cnt <= word_cnt + CNT_WIDTH'(1);
    end
  end

`ifdef S2P_FRAME_CHECK_EN
  // Sticky mid-word frame flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         frame_err <= 1'b0;
    else if (mid_frame) frame_err <= 1'b1;
  end
`else
  assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_to_parallel_rx.sv
// -----------------------------------------------------------------------------
// tb_serial_to_parallel_rx
//
// Self-checking bench for serial_to_parallel_rx. Two instances share stimulus:
// the default configuration and one with a 4-bit word counter for wrap
// checking. A word-level reference model (a queue of pairs, a completed-word
// count and sticky flags) predicts every output each cycle.
// -----------------------------------------------------------------------------
module tb_serial_to_parallel_rx;

  localparam int WIDTH = 16;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic reset, frame, serial_L, serial_R, out_ready;

  logic             out_valid, overflow, frame_err;
  logic [WIDTH-1:0] data_L, data_R;
  logic [15:0]      word_cnt;

  logic             out_valid4, overflow4, frame_err4;
  logic [WIDTH-1:0] data_L4, data_R4;
  logic [3:0]       word_cnt4;

  int vectors_applied = 0;
  int miscompares     = 0;

  // Reference model state.
  logic [31:0] model_q[$];
  int          model_cnt;
  bit          model_ovf, model_ferr;
  logic [15:0] last_l, last_r;

  always #5 clk = ~clk;

  serial_to_parallel_rx #(.WIDTH(WIDTH), .FIFO_DEPTH(DEPTH), .CNT_WIDTH(16)) u_dut (
    .clk(clk), .reset(reset), .frame(frame), .serial_L(serial_L),
    .serial_R(serial_R), .out_ready(out_ready), .out_valid(out_valid),
    .data_L(data_L), .data_R(data_R), .overflow(overflow),
    .frame_err(frame_err), .word_cnt(word_cnt)
  );

  serial_to_parallel_rx #(.WIDTH(WIDTH), .FIFO_DEPTH(DEPTH), .CNT_WIDTH(4)) u_dut4 (
    .clk(clk), .reset(reset), .frame(frame), .serial_L(serial_L),
    .serial_R(serial_R), .out_ready(out_ready), .out_valid(out_valid4),
    .data_L(data_L4), .data_R(data_R4), .overflow(overflow4),
    .frame_err(frame_err4), .word_cnt(word_cnt4)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors_applied++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    model_q.delete();
    model_cnt  = 0;
    model_ovf  = 1'b0;
    model_ferr = 1'b0;
    last_l     = '0;
    last_r     = '0;
  endtask

  task automatic checkAll();
    checkOutput("out_valid", 32'(out_valid), 32'(model_q.size() != 0));
    checkOutput("data_L",    32'(data_L),    32'(last_l));
    checkOutput("data_R",    32'(data_R),    32'(last_r));
    checkOutput("overflow",  32'(overflow),  32'(model_ovf));
    checkOutput("frame_err", 32'(frame_err), 32'(model_ferr));
    checkOutput("word_cnt",  32'(word_cnt),  32'(model_cnt % 65536));
    checkOutput("out_valid4", 32'(out_valid4), 32'(model_q.size() != 0));
    checkOutput("data_L4",    32'(data_L4),    32'(last_l));
    checkOutput("data_R4",    32'(data_R4),    32'(last_r));
    checkOutput("overflow4",  32'(overflow4),  32'(model_ovf));
    checkOutput("frame_err4", 32'(frame_err4), 32'(model_ferr));
    checkOutput("word_cnt4",  32'(word_cnt4),  32'(model_cnt % 16));
  endtask

  // One clock cycle: drive inputs, advance the model on the posedge, then
  // compare on the following negedge. `complete` marks the word's last bit.
  task automatic applyStimulus(input logic f, input logic sl, input logic sr,
                               input logic rdy, input bit complete,
                               input logic [31:0] word, input bit set_ferr);
    frame     = f;
    serial_L  = sl;
    serial_R  = sr;
    out_ready = rdy;
    @(posedge clk);
    if (model_q.size() > 0 && rdy) void'(model_q.pop_front());
    if (complete) begin
      model_cnt++;
      if (model_q.size() < DEPTH) model_q.push_back(word);
      else                        model_ovf = 1'b1;
    end
    if (set_ferr) model_ferr = 1'b1;
    if (model_q.size() > 0) {last_l, last_r} = model_q[0];
    @(negedge clk);
    checkAll();
  endtask

  // ready_mode: 0 never, 1 always, 2 random, 3 only on the last bit.
  // mid >= 1 pulses an extra frame at that bit position.
  task automatic sendWord(input logic [15:0] l, input logic [15:0] r,
                          input int ready_mode, input int mid);
    for (int i = 0; i < WIDTH; i++) begin
      logic f, rdy;
      bit   complete, set_ferr;
      f        = (i == 0) || (i == mid);
      complete = (i == WIDTH - 1);
      set_ferr = 1'b0;
`ifdef S2P_FRAME_CHECK_EN
      if (mid > 0) begin
        complete = 1'b0;
        set_ferr = (i == mid);
      end
`endif
      case (ready_mode)
        0:       rdy = 1'b0;
        1:       rdy = 1'b1;
        2:       rdy = 1'($urandom_range(0, 1));
        default: rdy = (i == WIDTH - 1);
      endcase
      applyStimulus(f, l[WIDTH-1-i], r[WIDTH-1-i], rdy, complete, {l, r}, set_ferr);
    end
  endtask

  task automatic idleCycles(input int n, input logic rdy);
    for (int i = 0; i < n; i++)
      applyStimulus(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    rdy, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic doReset();
    reset     = 1'b0;
    frame     = 1'b0;
    out_ready = 1'b0;
    modelReset();
    @(negedge clk);
    @(negedge clk);
    checkAll();
    reset = 1'b1;
  endtask

  initial begin
    reset     = 1'b0;
    frame     = 1'b0;
    serial_L  = 1'b0;
    serial_R  = 1'b0;
    out_ready = 1'b0;
    modelReset();

    // Reset state.
    doReset();

    // Single word held with no consumer.
    sendWord(16'hA5C3, 16'h0F0F, 0, -1);
    checkOutput("single_valid",  32'(out_valid), 32'd1);
    checkOutput("single_data_L", 32'(data_L),    32'h0000A5C3);
    checkOutput("single_data_R", 32'(data_R),    32'h00000F0F);
    checkOutput("single_cnt",    32'(word_cnt),  32'd1);

    // Back-to-back words into a full FIFO; third pair dropped.
    doReset();
    sendWord(16'h1111, 16'h2222, 0, -1);
    sendWord(16'h3333, 16'h4444, 0, -1);
    sendWord(16'h5555, 16'h6666, 0, -1);
    checkOutput("full_overflow", 32'(overflow), 32'd1);
    checkOutput("full_cnt",      32'(word_cnt), 32'd3);
    checkOutput("full_head_L",   32'(data_L),   32'h00001111);
    idleCycles(1, 1'b1);
    checkOutput("pop1_head_L",   32'(data_L),   32'h00003333);
    checkOutput("pop1_head_R",   32'(data_R),   32'h00004444);
    idleCycles(1, 1'b1);
    checkOutput("pop2_valid",    32'(out_valid), 32'd0);
    idleCycles(2, 1'b0);

    // Push coinciding with a pop while full.
    doReset();
    sendWord(16'h1111, 16'h2222, 0, -1);
    sendWord(16'h3333, 16'h4444, 0, -1);
    sendWord(16'h7777, 16'h8888, 3, -1);
    checkOutput("pushpop_overflow", 32'(overflow), 32'd0);
    checkOutput("pushpop_head_L",   32'(data_L),   32'h00003333);
    checkOutput("pushpop_cnt",      32'(word_cnt), 32'd3);
    idleCycles(1, 1'b1);
    checkOutput("pushpop_tail_L",   32'(data_L),   32'h00007777);
    checkOutput("pushpop_tail_R",   32'(data_R),   32'h00008888);
    idleCycles(2, 1'b1);

    // Mid-word frame.
    doReset();
    sendWord(16'hABCD, 16'h1234, 0, 8);
    sendWord(16'h5A5A, 16'hA5A5, 0, -1);
`ifdef S2P_FRAME_CHECK_EN
    checkOutput("mid_frame_err", 32'(frame_err), 32'd1);
    checkOutput("mid_cnt",       32'(word_cnt),  32'd1);
    checkOutput("mid_head_L",    32'(data_L),    32'h00005A5A);
`else
    checkOutput("mid_frame_err", 32'(frame_err), 32'd0);
    checkOutput("mid_cnt",       32'(word_cnt),  32'd2);
    checkOutput("mid_head_L",    32'(data_L),    32'h0000ABCD);
    checkOutput("mid_head_R",    32'(data_R),    32'h00001234);
`endif
    idleCycles(3, 1'b1);

    // Asynchronous reset in the middle of a word.
    doReset();
    sendWord(16'h1234, 16'h4321, 0, -1);
    for (int i = 0; i < 5; i++)
      applyStimulus(i == 0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    modelReset();
    checkOutput("async_valid", 32'(out_valid), 32'd0);
    checkOutput("async_data_L", 32'(data_L),   32'd0);
    checkOutput("async_cnt",   32'(word_cnt),  32'd0);
    @(negedge clk);
    checkAll();
    reset = 1'b1;
    sendWord(16'h00FF, 16'hFF00, 0, -1);
    checkOutput("post_reset_cnt", 32'(word_cnt), 32'd1);
    checkOutput("post_reset_L",   32'(data_L),   32'h000000FF);
    checkOutput("post_reset_R",   32'(data_R),   32'h0000FF00);

    // Counter wrap on the 4-bit instance with continuous draining.
    doReset();
    for (int w = 0; w < 16; w++)
      sendWord(16'($urandom), 16'($urandom), 1, -1);
    checkOutput("wrap_cnt4",  32'(word_cnt4), 32'd0);
    checkOutput("wrap_cnt16", 32'(word_cnt),  32'd16);
    idleCycles(2, 1'b1);

    // Randomised traffic: random data, gaps and consumer behaviour.
    doReset();
    for (int w = 0; w < 60; w++) begin
      sendWord(16'($urandom), 16'($urandom), 2, -1);
      idleCycles($urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end
    idleCycles(4, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule
